// File: rtl/mem_port_arbiter_if.sv
// Bundles the ifetch, load/store and memory-port signals of mem_port_arbiter.
// Direction suffixes are from the arbiter's point of view; slave = arbiter, master = environment.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [31:0]       if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic [1:0]        ls_size_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [1:0]        mem_size_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              timeout_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_size_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output timeout_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_size_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  timeout_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between ifetch and load/store, one outstanding transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (load/store first).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned WAIT_MAX = 255
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRsp} state_e;

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_owner_ls;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_size;
  logic              r_timeout;

  logic w_accept;
  logic w_pick_ls;
  logic w_done;
  logic w_expire;
  logic w_cnt_last;

  assign w_accept   = (r_state == StIdle) && (bus.if_req_i || bus.ls_req_i);
  assign w_cnt_last = (r_cnt == CNT_W'(WAIT_MAX - 1));
  assign w_done     = bus.mem_rvalid_i &&
                      ((r_state == StWaitRsp) || ((r_state == StWaitGnt) && bus.mem_gnt_i));

`ifdef MEM_ARB_RR_EN
  // The owner of the last grant is also the last-served requester; on a tie the other one wins.
  assign w_pick_ls = bus.ls_req_i && (!bus.if_req_i || !r_owner_ls);
`else
  assign w_pick_ls = bus.ls_req_i;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_expire  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_d = StWaitGnt;
      end
      StWaitGnt, StWaitRsp: begin
        if (w_done) begin
          w_state_d = StIdle;
        end else if ((r_state == StWaitGnt) && bus.mem_gnt_i) begin
          w_state_d = StWaitRsp;
        end else if (w_cnt_last) begin
          w_state_d = StIdle;
          w_expire  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_state_d != r_state) begin
      w_cnt_d = '0;
    end else if ((r_state != StIdle) && (r_cnt != CNT_W'(WAIT_MAX))) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.if_gnt_o    = w_accept && !w_pick_ls;
    bus.ls_gnt_o    = w_accept && w_pick_ls;
    bus.mem_req_o   = (r_state == StWaitGnt);
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_size_o  = '0;
    if (r_state == StWaitGnt) begin
      bus.mem_we_o    = r_we;
      bus.mem_addr_o  = r_addr;
      bus.mem_wdata_o = r_wdata;
      bus.mem_size_o  = r_size;
    end
    bus.if_rvalid_o = w_done && !r_owner_ls;
    bus.ls_rvalid_o = w_done && r_owner_ls;
    bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i[31:0] : 32'd0;
    bus.ls_rdata_o  = bus.ls_rvalid_o ? bus.mem_rdata_i : '0;
    bus.timeout_o   = r_timeout;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_owner_ls <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      if (w_expire) r_timeout <= 1'b1;
      if (w_accept) begin
        r_owner_ls <= w_pick_ls;
        if (w_pick_ls) begin
          r_we    <= bus.ls_we_i;
          r_addr  <= bus.ls_addr_i;
          r_wdata <= bus.ls_wdata_i;
          r_size  <= bus.ls_size_i;
        end else begin
          r_we    <= 1'b0;
          r_addr  <= bus.if_addr_i;
          r_wdata <= '0;
          r_size  <= 2'd2;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned WAIT_MAX = 8;

  logic clock;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_MAX(WAIT_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        if_req;
    logic [63:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [1:0]  ls_size;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
  } in_t;

  typedef struct {
    logic        if_gnt;
    logic        ls_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        timeout;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level reference model.
  bit          m_busy;
  bit          m_mem_took;
  int          m_age;
  bit          m_ls;
  bit          m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_size;
  bit          m_last_ls;
  bit          m_timeout;

  function automatic in_t mk_in(logic if_req, logic [63:0] if_addr, logic ls_req, logic ls_we,
                                logic [63:0] ls_addr, logic [63:0] ls_wdata, logic [1:0] ls_size,
                                logic mem_gnt, logic mem_rvalid, logic [63:0] mem_rdata);
    in_t v;
    v.if_req = if_req;   v.if_addr = if_addr;
    v.ls_req = ls_req;   v.ls_we = ls_we;   v.ls_addr = ls_addr;
    v.ls_wdata = ls_wdata; v.ls_size = ls_size;
    v.mem_gnt = mem_gnt; v.mem_rvalid = mem_rvalid; v.mem_rdata = mem_rdata;
    return v;
  endfunction

  function automatic out_t mk_out(logic if_gnt, logic ls_gnt, logic if_rvalid, logic [31:0] if_rdata,
                                  logic ls_rvalid, logic [63:0] ls_rdata, logic mem_req,
                                  logic mem_we, logic [1:0] mem_size, logic [63:0] mem_addr,
                                  logic [63:0] mem_wdata, logic timeout);
    out_t o;
    o.if_gnt = if_gnt;   o.ls_gnt = ls_gnt;
    o.if_rvalid = if_rvalid; o.if_rdata = if_rdata;
    o.ls_rvalid = ls_rvalid; o.ls_rdata = ls_rdata;
    o.mem_req = mem_req; o.mem_we = mem_we; o.mem_size = mem_size;
    o.mem_addr = mem_addr; o.mem_wdata = mem_wdata; o.timeout = timeout;
    return o;
  endfunction

  function automatic in_t idle_in();
    return mk_in(0, 64'd0, 0, 0, 64'd0, 64'd0, 2'd0, 0, 0, 64'd0);
  endfunction

  function automatic out_t zero_out();
    return mk_out(0, 0, 0, 32'd0, 0, 64'd0, 0, 0, 2'd0, 64'd0, 64'd0, 0);
  endfunction

  function automatic bit model_winner_ls(in_t v);
    if (v.if_req && v.ls_req) begin
`ifdef MEM_ARB_RR_EN
      return !m_last_ls;
`else
      return 1'b1;
`endif
    end
    return v.ls_req;
  endfunction

  function automatic out_t model_out(in_t v);
    out_t o;
    bit   w;
    o = zero_out();
    o.timeout = m_timeout;
    if (!m_busy) begin
      if (v.if_req || v.ls_req) begin
        w = model_winner_ls(v);
        o.ls_gnt = w;
        o.if_gnt = !w;
      end
    end else begin
      if (!m_mem_took) begin
        o.mem_req = 1'b1;   o.mem_we = m_we;     o.mem_size = m_size;
        o.mem_addr = m_addr; o.mem_wdata = m_wdata;
      end
      if (v.mem_rvalid && (m_mem_took || v.mem_gnt)) begin
        if (m_ls) begin
          o.ls_rvalid = 1'b1; o.ls_rdata = v.mem_rdata;
        end else begin
          o.if_rvalid = 1'b1; o.if_rdata = v.mem_rdata[31:0];
        end
      end
    end
    return o;
  endfunction

  task automatic model_step(input in_t v);
    bit w;
    if (!m_busy) begin
      if (v.if_req || v.ls_req) begin
        w = model_winner_ls(v);
        m_busy = 1; m_mem_took = 0; m_age = 0; m_ls = w; m_last_ls = w;
        m_we    = w ? v.ls_we    : 1'b0;
        m_addr  = w ? v.ls_addr  : v.if_addr;
        m_wdata = w ? v.ls_wdata : 64'd0;
        m_size  = w ? v.ls_size  : 2'd2;
      end
    end else if (v.mem_rvalid && (m_mem_took || v.mem_gnt)) begin
      m_busy = 0;
    end else if (!m_mem_took && v.mem_gnt) begin
      m_mem_took = 1; m_age = 0;
    end else if (m_age == int'(WAIT_MAX) - 1) begin
      m_busy = 0; m_timeout = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_mem_took = 0; m_age = 0; m_ls = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_size = '0; m_last_ls = 0; m_timeout = 0;
  endtask

  task automatic cmp(input string tag, input string field, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h (t=%0t)", tag, field, act, exp, $time);
    end
  endtask

  task automatic check_all(input out_t e, input string tag);
    cmp(tag, "if_gnt",    64'(bus.if_gnt_o),    64'(e.if_gnt));
    cmp(tag, "ls_gnt",    64'(bus.ls_gnt_o),    64'(e.ls_gnt));
    cmp(tag, "if_rvalid", 64'(bus.if_rvalid_o), 64'(e.if_rvalid));
    cmp(tag, "if_rdata",  64'(bus.if_rdata_o),  64'(e.if_rdata));
    cmp(tag, "ls_rvalid", 64'(bus.ls_rvalid_o), 64'(e.ls_rvalid));
    cmp(tag, "ls_rdata",  bus.ls_rdata_o,       e.ls_rdata);
    cmp(tag, "mem_req",   64'(bus.mem_req_o),   64'(e.mem_req));
    cmp(tag, "mem_we",    64'(bus.mem_we_o),    64'(e.mem_we));
    cmp(tag, "mem_size",  64'(bus.mem_size_o),  64'(e.mem_size));
    cmp(tag, "mem_addr",  bus.mem_addr_o,       e.mem_addr);
    cmp(tag, "mem_wdata", bus.mem_wdata_o,      e.mem_wdata);
    cmp(tag, "timeout",   64'(bus.timeout_o),   64'(e.timeout));
  endtask

  task automatic apply(input in_t v);
    bus.if_req_i     = v.if_req;
    bus.if_addr_i    = v.if_addr;
    bus.ls_req_i     = v.ls_req;
    bus.ls_we_i      = v.ls_we;
    bus.ls_addr_i    = v.ls_addr;
    bus.ls_wdata_i   = v.ls_wdata;
    bus.ls_size_i    = v.ls_size;
    bus.mem_gnt_i    = v.mem_gnt;
    bus.mem_rvalid_i = v.mem_rvalid;
    bus.mem_rdata_i  = v.mem_rdata;
  endtask

  task automatic finish_cycle(input in_t v);
    @(posedge clock);
    model_step(v);
    #1;
  endtask

  task automatic run_cycle(input in_t v, input string tag);
    apply(v);
    #2;
    check_all(model_out(v), tag);
    finish_cycle(v);
  endtask

  task automatic do_reset();
    apply(idle_in());
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_all(zero_out(), "reset");
    reset = 1'b0;
    model_reset();
  endtask

  vec_t vecs[12];

  initial begin
    in_t        v;
    logic [1:0] exp_order[4];

    // {if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_size, mem_gnt, mem_rvalid, mem_rdata}
    // {if_gnt, ls_gnt, if_rvalid, if_rdata, ls_rvalid, ls_rdata, mem_req, mem_we, mem_size,
    //  mem_addr, mem_wdata, timeout}
    vecs[0].in  = mk_in(1, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0].exp = mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1].in  = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[1].exp = mk_out(0, 0, 0, 0, 0, 0, 1, 0, 2, 64'h8000_0000, 0, 0);
    vecs[2].in  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hAAAA_BBBB_0000_0013);
    vecs[2].exp = mk_out(0, 0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3].in  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    vecs[3].exp = zero_out();
    vecs[4].in  = mk_in(0, 0, 1, 1, 64'h8000_1000, 64'hDEAD_BEEF, 2, 0, 0, 0);
    vecs[4].exp = mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5].in  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1234);
    vecs[5].exp = mk_out(0, 0, 0, 0, 0, 0, 1, 1, 2, 64'h8000_1000, 64'hDEAD_BEEF, 0);
    vecs[6].in  = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h55);
    vecs[6].exp = mk_out(0, 0, 0, 0, 1, 64'h55, 1, 1, 2, 64'h8000_1000, 64'hDEAD_BEEF, 0);
    vecs[7].in  = idle_in();
    vecs[7].exp = zero_out();
    vecs[8].in  = mk_in(0, 0, 1, 0, 64'h8000_2000, 0, 3, 0, 0, 0);
    vecs[8].exp = mk_out(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9].in  = mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[9].exp = mk_out(0, 0, 0, 0, 0, 0, 1, 0, 3, 64'h8000_2000, 0, 0);
    vecs[10].in  = idle_in();
    vecs[10].exp = zero_out();
    vecs[11].in  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h1122_3344_5566_7788);
    vecs[11].exp = mk_out(0, 0, 0, 0, 1, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    model_reset();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].in);
      #2;
      check_all(vecs[i].exp, $sformatf("vec%0d", i));
      finish_cycle(vecs[i].in);
    end

    // Both requesters hold req through four back-to-back transactions.
`ifdef MEM_ARB_RR_EN
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
`else
    exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01; exp_order[3] = 2'b01;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v = mk_in(1, 64'h8000_0100, 1, 0, 64'h8000_3000, 0, 1, 0, 0, 0);
      apply(v);
      #2;
      cmp("tie", $sformatf("gnt%0d", k), 64'({bus.if_gnt_o, bus.ls_gnt_o}), 64'(exp_order[k]));
      check_all(model_out(v), "tie_idle");
      finish_cycle(v);
      v.mem_gnt = 1;
      run_cycle(v, "tie_gnt");
      v.mem_gnt = 0; v.mem_rvalid = 1; v.mem_rdata = 64'(k);
      run_cycle(v, "tie_rsp");
    end

    // Memory never grants: abandon after WAIT_MAX cycles, then a normal fetch.
    do_reset();
    run_cycle(mk_in(1, 64'h8000_0040, 0, 0, 0, 0, 0, 0, 0, 0), "stall_acc");
    for (int c = 0; c < int'(WAIT_MAX); c++) begin
      v = idle_in();
      apply(v);
      #2;
      cmp("stall", "mem_req", 64'(bus.mem_req_o), 64'd1);
      cmp("stall", "timeout", 64'(bus.timeout_o), 64'd0);
      finish_cycle(v);
    end
    v = mk_in(1, 64'h8000_0044, 0, 0, 0, 0, 0, 0, 1, 64'h77);
    apply(v);
    #2;
    cmp("stall_end", "timeout", 64'(bus.timeout_o), 64'd1);
    cmp("stall_end", "mem_req", 64'(bus.mem_req_o), 64'd0);
    cmp("stall_end", "if_gnt", 64'(bus.if_gnt_o), 64'd1);
    cmp("stall_end", "rvalid", 64'({bus.if_rvalid_o, bus.ls_rvalid_o}), 64'd0);
    check_all(model_out(v), "stall_end");
    finish_cycle(v);
    run_cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "after_gnt");
    v = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0000_0093);
    apply(v);
    #2;
    cmp("after_rsp", "if_rvalid", 64'(bus.if_rvalid_o), 64'd1);
    cmp("after_rsp", "if_rdata", 64'(bus.if_rdata_o), 64'h93);
    cmp("after_rsp", "timeout", 64'(bus.timeout_o), 64'd1);
    finish_cycle(v);

    // Reset while waiting for the response; the late response must be dropped.
    do_reset();
    run_cycle(mk_in(0, 0, 1, 0, 64'h8000_0200, 0, 3, 0, 0, 0), "rst_acc");
    run_cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rst_gnt");
    apply(idle_in());
    reset = 1'b1;
    #2;
    check_all(zero_out(), "rst_mid");
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    v = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hCAFE_F00D);
    apply(v);
    #2;
    check_all(zero_out(), "rst_late_rsp");
    finish_cycle(v);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v.if_req     = 1'($urandom_range(0, 1));
      v.if_addr    = {$urandom(), $urandom()};
      v.ls_req     = 1'($urandom_range(0, 1));
      v.ls_we      = 1'($urandom_range(0, 1));
      v.ls_addr    = {$urandom(), $urandom()};
      v.ls_wdata   = {$urandom(), $urandom()};
      v.ls_size    = 2'($urandom_range(0, 3));
      v.mem_gnt    = ($urandom_range(0, 4) == 0);
      v.mem_rvalid = 1'($urandom_range(0, 1));
      v.mem_rdata  = {$urandom(), $urandom()};
      run_cycle(v, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
